// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution tile sequencer:
// state encoding, instruction-bus bit positions and the pmem shift helper.
package conv_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST,
        S_KPRIME,
        S_KLOAD,
        S_KINT,
        S_ACT,
        S_ACTGAP,
        S_EXEC,
        S_EXGAP,
        S_OPRIME,
        S_ODRAIN,
        S_OEND,
        S_GAP
    } seq_state_t;

    // Default geometry of the dual_core array this sequencer drives
    localparam int DEF_COL    = 8;
    localparam int DEF_ROW    = 8;
    localparam int DEF_KSZ    = 3;
    localparam int DEF_NIJ_SZ = 6;
    localparam int DEF_HTILES = 2;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_X_BASE = 0;
    localparam int DEF_W_BASE = 1024;

    // Instruction bus layout (bit positions, LSB of each field)
    localparam int INST_W     = 34;
    localparam int INST_AW    = 11;
    localparam int B_LOAD     = 0;
    localparam int B_EXECUTE  = 1;
    localparam int B_L0_WR    = 2;
    localparam int B_L0_RD    = 3;
    localparam int B_IFIFO_RD = 4;
    localparam int B_IFIFO_WR = 5;
    localparam int B_OFIFO_RD = 6;
    localparam int B_A_XMEM   = 7;
    localparam int B_WEN_XMEM = 18;
    localparam int B_CEN_XMEM = 19;
    localparam int B_A_PMEM   = 20;
    localparam int B_WEN_PMEM = 31;
    localparam int B_CEN_PMEM = 32;
    localparam int B_ACC      = 33;

    typedef struct packed {
        logic               acc;
        logic               cen_pmem;
        logic               wen_pmem;
        logic [INST_AW-1:0] a_pmem;
        logic               cen_xmem;
        logic               wen_xmem;
        logic [INST_AW-1:0] a_xmem;
        logic               ofifo_rd;
        logic               ififo_wr;
        logic               ififo_rd;
        logic               l0_rd;
        logic               l0_wr;
        logic               execute;
        logic               load;
    } inst_fields_t;

    // Memories disabled, everything else quiet
    localparam inst_fields_t INST_IDLE = '{cen_pmem: 1'b1, wen_pmem: 1'b1,
                                           cen_xmem: 1'b1, wen_xmem: 1'b1,
                                           default: '0};

    // Output rows are written back shifted by the kernel offset so that
    // partial sums of every kij line up in pmem; the caller truncates.
    function automatic int pmem_shift(input int kx, input int ky, input int nij_sz);
        return -(kx + ky * nij_sz);
    endfunction

endpackage

// File: rtl/conv_tile_sequencer_if.sv
// Control and instruction bus between the sequencer and dual_core.
interface conv_tile_sequencer_if
    import conv_seq_pkg::*;
#(
    parameter int HTILES = DEF_HTILES
);
    logic              start;
    logic              relu_en;
    logic              busy;
    logic              done;
    logic [INST_W-1:0] inst;
    logic              mode;
    logic              sel;
    logic [HTILES-1:0] tile;
    logic              relu;
    logic              core_rst;

    modport master (
        input  start, relu_en,
        output busy, done, inst, mode, sel, tile, relu, core_rst
    );

    modport slave (
        output start, relu_en,
        input  busy, done, inst, mode, sel, tile, relu, core_rst
    );
endinterface

// File: rtl/inst_pack.sv
// Packs the named instruction fields into the 34-bit dual_core inst word.
module inst_pack
    import conv_seq_pkg::*;
(
    input  inst_fields_t      f,
    output logic [INST_W-1:0] inst
);

    // Place every field at its fixed bus position
    always_comb begin
        inst                          = '0;
        inst[B_LOAD]                  = f.load;
        inst[B_EXECUTE]               = f.execute;
        inst[B_L0_WR]                 = f.l0_wr;
        inst[B_L0_RD]                 = f.l0_rd;
        inst[B_IFIFO_RD]              = f.ififo_rd;
        inst[B_IFIFO_WR]              = f.ififo_wr;
        inst[B_OFIFO_RD]              = f.ofifo_rd;
        inst[B_A_XMEM +: INST_AW]     = f.a_xmem;
        inst[B_WEN_XMEM]              = f.wen_xmem;
        inst[B_CEN_XMEM]              = f.cen_xmem;
        inst[B_A_PMEM +: INST_AW]     = f.a_pmem;
        inst[B_WEN_PMEM]              = f.wen_pmem;
        inst[B_CEN_PMEM]              = f.cen_pmem;
        inst[B_ACC]                   = f.acc;
    end

endmodule

// File: rtl/conv_tile_sequencer.sv
// Hardware kij-loop sequencer for dual_core: per kernel position it loads
// weights tile by tile, fills activations, executes and drains the OFIFO
// into pmem at the shifted address. All outputs are registered.
module conv_tile_sequencer
    import conv_seq_pkg::*;
#(
    parameter int COL    = DEF_COL,
    parameter int ROW    = DEF_ROW,
    parameter int KSZ    = DEF_KSZ,
    parameter int NIJ_SZ = DEF_NIJ_SZ,
    parameter int HTILES = DEF_HTILES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int X_BASE = DEF_X_BASE,
    parameter int W_BASE = DEF_W_BASE
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_tile_sequencer_if.master  bus
);

    localparam int LEN_NIJ = NIJ_SZ * NIJ_SZ;
    localparam int KIJ_N   = KSZ * KSZ;
    localparam int KLOAD_N = ROW + 2 * COL;
    localparam int EXEC_N  = LEN_NIJ + 2 * COL;
    localparam int TW      = $clog2(LEN_NIJ + KLOAD_N + 2 * COL + 1);
    localparam int JW      = (HTILES > 1) ? $clog2(HTILES) : 1;
    localparam int KW      = $clog2(KIJ_N + 1);
    localparam int XW      = $clog2(KSZ + 1);

    seq_state_t        state_q, state_d;
    logic [TW-1:0]     t_q, t_d;
    logic [JW-1:0]     j_q, j_d;
    logic [KW-1:0]     kij_q, kij_d;
    logic [XW-1:0]     kx_q, kx_d, ky_q, ky_d;
    logic              relu_en_q, relu_en_d, relu_q, relu_d;
    inst_fields_t      f_q, f_d;
    logic              sel_q, sel_d, core_rst_q, core_rst_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [HTILES-1:0] tile_q, tile_d, tile_onehot;
    logic [ADDR_W-1:0] w_base, p_shift;

    // Next state, loop counters, then the output image of the state being entered
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        j_d       = j_q;
        kij_d     = kij_q;
        kx_d      = kx_q;
        ky_d      = ky_q;
        relu_en_d = relu_en_q;
        relu_d    = relu_q;
        done_d    = 1'b0;

        case (state_q)
            // A start landing on the done pulse belongs to the run just finished
            S_IDLE: if (bus.start && !done_q) begin
                state_d   = S_RST;
                t_d       = '0;
                j_d       = '0;
                kij_d     = '0;
                kx_d      = '0;
                ky_d      = '0;
                relu_en_d = bus.relu_en;
                relu_d    = 1'b0;
            end
            S_RST: if (t_q == TW'(2)) begin
                state_d = S_KPRIME;
                t_d     = '0;
                j_d     = '0;
            end else t_d = t_q + TW'(1);
            S_KPRIME: begin
                state_d = S_KLOAD;
                t_d     = '0;
            end
            S_KLOAD: if (t_q == TW'(KLOAD_N - 1)) state_d = S_KINT;
                     else t_d = t_q + TW'(1);
            S_KINT: if (j_q == JW'(HTILES - 1)) begin
                state_d = S_ACT;
                t_d     = '0;
            end else begin
                state_d = S_KPRIME;
                j_d     = j_q + JW'(1);
            end
            S_ACT: if (t_q == TW'(LEN_NIJ - 1)) state_d = S_ACTGAP;
                   else t_d = t_q + TW'(1);
            S_ACTGAP: begin
                state_d = S_EXEC;
                t_d     = '0;
            end
            S_EXEC: if (t_q == TW'(EXEC_N - 1)) state_d = S_EXGAP;
                    else t_d = t_q + TW'(1);
            S_EXGAP: begin
                state_d = S_OPRIME;
                if (relu_en_q && kij_q == KW'(KIJ_N - 1)) relu_d = 1'b1;
            end
            S_OPRIME: begin
                state_d = S_ODRAIN;
                t_d     = '0;
            end
            S_ODRAIN: if (t_q == TW'(LEN_NIJ - 1)) state_d = S_OEND;
                      else t_d = t_q + TW'(1);
            S_OEND: begin
                state_d = S_GAP;
                t_d     = '0;
            end
            S_GAP: if (t_q == TW'(1)) begin
                if (kij_q == KW'(KIJ_N - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RST;
                    t_d     = '0;
                    kij_d   = kij_q + KW'(1);
                    if (kx_q == XW'(KSZ - 1)) begin
                        kx_d = '0;
                        ky_d = ky_q + XW'(1);
                    end else kx_d = kx_q + XW'(1);
                end
            end else t_d = t_q + TW'(1);
            default: state_d = S_IDLE;
        endcase

        w_base      = ADDR_W'(W_BASE + (int'(kij_d) * HTILES + int'(j_d)) * 2 * COL);
        p_shift     = ADDR_W'(pmem_shift(int'(kx_d), int'(ky_d), NIJ_SZ));
        tile_onehot = HTILES'(1) << j_d;

        f_d        = INST_IDLE;
        sel_d      = 1'b0;
        tile_d     = '0;
        core_rst_d = 1'b0;
        busy_d     = (state_d != S_IDLE);

        case (state_d)
            S_RST: core_rst_d = (t_d == '0);
            S_KPRIME: begin
                tile_d     = tile_onehot;
                f_d.l0_wr  = 1'b1;
                f_d.cen_xmem = 1'b0;
                f_d.a_xmem = INST_AW'(w_base);
            end
            S_KLOAD: begin
                tile_d     = tile_onehot;
                f_d.l0_rd  = 1'b1;
                f_d.load   = (t_d < TW'(2 * COL));
                f_d.a_xmem = INST_AW'(w_base + ADDR_W'(t_d) + ADDR_W'(1));
                if (t_d < TW'(2 * COL - 1)) begin
                    f_d.l0_wr    = 1'b1;
                    f_d.cen_xmem = 1'b0;
                end
            end
            S_KINT: tile_d = tile_onehot;
            S_ACT: begin
                tile_d       = '1;
                f_d.l0_wr    = 1'b1;
                f_d.cen_xmem = 1'b0;
                f_d.a_xmem   = INST_AW'(ADDR_W'(X_BASE) + ADDR_W'(t_d));
            end
            S_EXEC: begin
                tile_d      = '1;
                f_d.l0_rd   = 1'b1;
                f_d.execute = (t_d < TW'(LEN_NIJ));
            end
            S_OPRIME: begin
                tile_d       = '1;
                sel_d        = kij_d[0];
                f_d.ofifo_rd = 1'b1;
                f_d.acc      = (kij_d != '0);
                f_d.a_pmem   = INST_AW'(p_shift);
            end
            S_ODRAIN: begin
                tile_d       = '1;
                sel_d        = kij_d[0];
                f_d.acc      = (kij_d != '0);
                f_d.ofifo_rd = (kij_d != '0);
                f_d.cen_pmem = 1'b0;
                f_d.wen_pmem = 1'b0;
                f_d.a_pmem   = INST_AW'(p_shift + ADDR_W'(t_d));
            end
            S_OEND: tile_d = '1;
            default: ;
        endcase
    end

    // State, counters and registered outputs; reset drops straight back to idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            j_q        <= '0;
            kij_q      <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            relu_en_q  <= 1'b0;
            relu_q     <= 1'b0;
            f_q        <= INST_IDLE;
            sel_q      <= 1'b0;
            tile_q     <= '0;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            j_q        <= j_d;
            kij_q      <= kij_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            relu_en_q  <= relu_en_d;
            relu_q     <= relu_d;
            f_q        <= f_d;
            sel_q      <= sel_d;
            tile_q     <= tile_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    inst_pack u_inst_pack (
        .f    (f_q),
        .inst (bus.inst)
    );

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mode     = 1'b0;
    assign bus.sel      = sel_q;
    assign bus.tile     = tile_q;
    assign bus.relu     = relu_q;
    assign bus.core_rst = core_rst_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Scoreboard bench for conv_tile_sequencer: stimulus queues expected
// KPRIME / KINT / OPRIME / end-of-run observations, a negedge monitor pops them.
module tb_conv_tile_sequencer;
    import conv_seq_pkg::*;

    localparam int EV_KPRIME = 0;
    localparam int EV_KINT   = 1;
    localparam int EV_OPRIME = 2;
    localparam int EV_RUN    = 3;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic use4;

    int n_checks;
    int n_pass;
    int run_count;

    exp_t sb[4][$];

    // Hand-computed pmem shifts for KSZ=3, NIJ_SZ=6: -(kx + 6*ky) mod 2048
    int pshift_def[9] = '{0, 2047, 2046, 2042, 2041, 2040, 2036, 2035, 2034};

    conv_tile_sequencer_if #(.HTILES(2)) bus ();
    conv_tile_sequencer_if #(.HTILES(4)) bus4 ();

    conv_tile_sequencer #(.HTILES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    conv_tile_sequencer #(.HTILES(4), .KSZ(1), .NIJ_SZ(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    logic [33:0] m_inst;
    logic [3:0]  m_tile;
    logic        m_busy, m_done, m_relu, m_sel, m_core_rst;

    // Observe whichever sequencer is currently under test
    always_comb begin
        if (use4) begin
            m_inst = bus4.inst; m_tile = bus4.tile; m_busy = bus4.busy;
            m_done = bus4.done; m_relu = bus4.relu; m_sel = bus4.sel;
            m_core_rst = bus4.core_rst;
        end else begin
            m_inst = bus.inst; m_tile = {2'b00, bus.tile}; m_busy = bus.busy;
            m_done = bus.done; m_relu = bus.relu; m_sel = bus.sel;
            m_core_rst = bus.core_rst;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input int kind, input string name, input logic [63:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb[kind].push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [63:0] act);
        exp_t e;
        if (sb[kind].size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_event_%0d: got 0x%0h, required no event", kind, act);
        end else begin
            e = sb[kind].pop_front();
            check_output(e.name, act, e.val);
        end
    endtask

    task automatic push_weights(input int kij, input int htiles);
        for (int j = 0; j < htiles; j++) begin
            push_exp(EV_KPRIME, $sformatf("kprime_k%0d_j%0d", kij, j),
                     64'({4'(1 << j), 11'(1024 + (kij * htiles + j) * 16)}));
            push_exp(EV_KINT, $sformatf("l0wr_load_pulses_k%0d_j%0d", kij, j),
                     64'({16'd16, 16'd16}));
        end
    endtask

    task automatic push_oprime(input int kij, input int shift, input bit relu);
        push_exp(EV_OPRIME, $sformatf("oprime_k%0d", kij),
                 64'({relu, 1'(kij & 1), kij > 0, 11'(shift)}));
    endtask

    task automatic apply_stimulus(input bit relu_en);
        @(negedge clk);
        if (use4) begin bus4.start = 1'b1; bus4.relu_en = relu_en; end
        else      begin bus.start  = 1'b1; bus.relu_en  = relu_en; end
        @(negedge clk);
        bus.start  = 1'b0;
        bus4.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("done_seen", 64'(m_done), 64'd1);
    endtask

    task automatic check_queues_empty(input string tag);
        for (int k = 0; k < 4; k++)
            check_output($sformatf("%s_pending_%0d", tag, k), 64'(sb[k].size()), 64'd0);
    endtask

    int  busy_cycles, l0wr_cnt, load_cnt;
    bit  relu_seen, busy_prev;
    logic onehot;
    assign onehot = (m_tile != 4'd0) && ((m_tile & (m_tile - 4'd1)) == 4'd0);

    // Monitor: classify each cycle's outputs and pop the matching expectation
    always @(negedge clk) begin
        if (reset) begin
            if (m_busy && !busy_prev) begin
                busy_cycles = 0; l0wr_cnt = 0; load_cnt = 0; relu_seen = 1'b0;
                run_count++;
            end
            busy_prev = m_busy;
            if (m_busy) begin
                busy_cycles++;
                if (m_relu) relu_seen = 1'b1;
            end
            if (onehot && m_inst[B_L0_WR]) l0wr_cnt++;
            if (onehot && m_inst[B_LOAD])  load_cnt++;
            if (onehot && m_inst[B_L0_WR] && !m_inst[B_L0_RD])
                pop_check(EV_KPRIME, 64'({m_tile, m_inst[B_A_XMEM +: 11]}));
            if (onehot && !m_inst[B_L0_WR] && !m_inst[B_L0_RD] && !m_inst[B_LOAD]) begin
                pop_check(EV_KINT, 64'({16'(l0wr_cnt), 16'(load_cnt)}));
                l0wr_cnt = 0;
                load_cnt = 0;
            end
            if (m_inst[B_OFIFO_RD] && m_inst[B_CEN_PMEM])
                pop_check(EV_OPRIME, 64'({m_relu, m_sel, m_inst[B_ACC], m_inst[B_A_PMEM +: 11]}));
            if (m_done)
                pop_check(EV_RUN, 64'({relu_seen, 32'(busy_cycles)}));
        end else begin
            busy_prev = 1'b0;
        end
    end

    initial begin
        int base_runs;
        n_checks = 0; n_pass = 0; run_count = 0;
        busy_prev = 1'b0; busy_cycles = 0; l0wr_cnt = 0; load_cnt = 0; relu_seen = 1'b0;
        use4 = 1'b0;
        reset = 1'b0;
        bus.start = 1'b0;  bus.relu_en = 1'b0;
        bus4.start = 1'b0; bus4.relu_en = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset_inst", 64'(bus.inst), 64'(34'h1_800C_0000));
        check_output("reset_busy", 64'(bus.busy), 64'd0);
        check_output("reset_done", 64'(bus.done), 64'd0);
        check_output("reset_tile_sel_relu_rst_mode",
                     64'({bus.tile, bus.sel, bus.relu, bus.core_rst, bus.mode}), 64'd0);
        reset = 1'b1;

        // Run interrupted by reset in the middle of kij 4 execute
        for (int k = 0; k < 5; k++) push_weights(k, 2);
        for (int k = 0; k < 4; k++) push_oprime(k, pshift_def[k], 1'b0);
        apply_stimulus(1'b1);
        check_output("core_rst_first_rst_cycle", 64'(m_core_rst), 64'd1);
        @(negedge clk);
        check_output("core_rst_second_rst_cycle", 64'(m_core_rst), 64'd0);
        repeat (839) @(negedge clk);
        check_output("kij4_exec_active", 64'(m_inst[B_EXECUTE]), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_output("async_reset_inst", 64'(bus.inst), 64'(34'h1_800C_0000));
        @(negedge clk);
        check_output("async_reset_busy", 64'(bus.busy), 64'd0);
        check_queues_empty("interrupted_run");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Full default run from kij 0 with ReLU, stray starts while busy and on done
        for (int k = 0; k < 9; k++) begin
            push_weights(k, 2);
            push_oprime(k, pshift_def[k], k == 8);
        end
        push_exp(EV_RUN, "run_default_relu1", 64'({1'b1, 32'd1665}));
        base_runs = run_count;
        apply_stimulus(1'b1);
        repeat (500) @(negedge clk);
        bus.start = 1'b1; bus.relu_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(3000);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_output("done_single_pulse", 64'(m_done), 64'd0);
        repeat (20) @(negedge clk);
        check_output("single_run", 64'(run_count - base_runs), 64'd1);
        check_output("idle_after_run", 64'(bus.busy), 64'd0);
        check_output("relu_holds_after_run", 64'(bus.relu), 64'd1);
        check_queues_empty("default_run");

        // Four tiles, 1x1 kernel, 4x4 map: 177 cycles, ReLU on the only OPRIME
        use4 = 1'b1;
        @(negedge clk);
        push_weights(0, 4);
        push_oprime(0, 0, 1'b1);
        push_exp(EV_RUN, "run_h4_relu1", 64'({1'b1, 32'd177}));
        apply_stimulus(1'b1);
        wait_done(400);
        repeat (3) @(negedge clk);
        check_queues_empty("h4_relu1");

        // Same geometry with ReLU disabled: relu never asserted
        push_weights(0, 4);
        push_oprime(0, 0, 1'b0);
        push_exp(EV_RUN, "run_h4_relu0", 64'({1'b0, 32'd177}));
        apply_stimulus(1'b0);
        wait_done(400);
        repeat (3) @(negedge clk);
        check_output("relu_off_after_run", 64'(bus4.relu), 64'd0);
        check_queues_empty("h4_relu0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
